// File: rtl/decoder_pkg.sv
// Shared state type and default sizing for the sequential 3-to-8 decoder.
package decoder_pkg;

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam int N_SEL_DEF       = 3;
  localparam int N_OUT_DEF       = 8;
  localparam int HOLD_CYCLES_DEF = 4;

endpackage

// File: rtl/decoder3to8_core.sv
// Combinational binary-to-one-hot expander; all-zero when disabled so the
// same block can serve a loop-back checker against the priority encoder.
module decoder3to8_core
  import decoder_pkg::*;
#(
  parameter int N_SEL = N_SEL_DEF,
  parameter int N_OUT = 2**N_SEL
) (
  input  logic             en,
  input  logic [N_SEL-1:0] y,
  output logic [N_OUT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[y] = 1'b1;
  end

endmodule

// File: rtl/decoder3to8_seq.sv
// Sequential 3-to-8 decoder: accepts a code over valid/ready, holds the matching
// one-hot line for HOLD_CYCLES (or until ack), then pulses done.
module decoder3to8_seq
  import decoder_pkg::*;
#(
  parameter int N_SEL       = N_SEL_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  localparam int N_OUT      = 2**N_SEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid,
  input  logic [N_SEL-1:0] y,
  output logic             ready,
  input  logic             ack,
  output logic [N_OUT-1:0] d,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_n;
  logic [N_OUT-1:0] d_n;
  logic [N_OUT-1:0] onehot;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_n, ready_n, done_n;

  decoder3to8_core #(
    .N_SEL (N_SEL),
    .N_OUT (N_OUT)
  ) u_core (
    .en     (en),
    .y      (y),
    .onehot (onehot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      d     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      d     <= d_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      ready <= ready_n;
      done  <= done_n;
    end
  end

  // In ACTIVE, a dropped enable outranks ack, and ack outranks the hold timer.
  always_comb begin
    state_n = state;
    d_n     = d;
    cnt_n   = cnt;
    busy_n  = busy;
    ready_n = ready;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (valid && ready && en) begin
          d_n     = onehot;
          cnt_n   = CNT_LOAD;
          busy_n  = 1'b1;
          ready_n = 1'b0;
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!en) begin
          d_n     = '0;
          busy_n  = 1'b0;
          ready_n = 1'b1;
          state_n = IDLE;
        end else if (ack || (cnt == '0)) begin
          d_n     = '0;
          busy_n  = 1'b0;
          ready_n = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
